multi_mode_runtime_tracker: RTL and testbench
=============================================

Name: multi_mode_runtime_tracker

Overview:
- Parametrised successor to the single-mode running-time counter. Tracks elapsed seconds for up to NUM_MODES hood operating modes.
- Per mode it keeps a per-session current time and a persistent lifetime total, plus a programmable session limit with a time-up flag.
- Sits beside the mode FSM; its outputs feed the display driver and the auto-off/clean-reminder logic.

Parameters:
- NUM_MODES, 4, number of tracked mode codes (codes 0..NUM_MODES-1).
- MODE_WIDTH, `MODE_WIDTH, width of current_mode.
- TIME_WIDTH, `MAX_WIDTH, width of every seconds counter.
- TICKS_PER_SEC, `COUNTER_1SEC, clk cycles per second. The tick period is exactly TICKS_PER_SEC cycles; must be >= 2.
- TRACK_MASK, {NUM_MODES{1'b1}}, bit i = 1 means mode i is counted. Untracked modes behave as idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- current_mode  in  MODE_WIDTH  mode code from the mode FSM.
- pause  in  1  freezes the prescaler and all counters while high.
- limit  in  TIME_WIDTH  session limit in seconds; 0 disables the limit.
- clear_total  in  NUM_MODES  per-mode clear strobe for the lifetime total.
- current_running_time  out  TIME_WIDTH  seconds in the present session of the active mode.
- total_running_time  out  NUM_MODES*TIME_WIDTH  flattened per-mode totals; mode i occupies bits [i*TIME_WIDTH +: TIME_WIDTH].
- sec_tick  out  1  one-cycle pulse on each counted second.
- time_up  out  1  level; high while current_running_time >= limit and limit != 0.
- active_idx  out  MODE_WIDTH  registered copy of the mode currently being counted.

Behaviour:
- Reset (rst=1 at a clk edge): prescaler, current_running_time, all totals, sec_tick, time_up and active_idx are cleared to 0. The mode_q register is loaded with current_mode. Reset takes priority over every other input.
- Active condition: current_mode < NUM_MODES and TRACK_MASK[current_mode] = 1.
- Mode change (current_mode != mode_q):
  - prescaler and current_running_time go to 0 and time_up goes low on that edge;
  - no tick is issued in that cycle;
  - mode_q and active_idx are updated on the same edge;
  - totals are unaffected.
- Inactive mode: prescaler and current_running_time are held at 0, sec_tick = 0, time_up = 0. Totals are held.
- Active, pause=0:
  - prescaler increments every cycle and wraps from TICKS_PER_SEC-1 to 0;
  - on the wrap edge, current_running_time and total[active] each +1 and sec_tick = 1 for exactly that cycle;
  - first tick arrives TICKS_PER_SEC cycles after mode entry.
- Saturation: current_running_time and every total stop at all-ones; they never wrap. sec_tick still pulses.
- Limit:
  - When the incremented current value equals limit (limit != 0), time_up rises registered, in the same cycle as the updated value.
  - current_running_time keeps counting past the limit.
  - Changing limit mid-session re-evaluates the comparison combinationally into the next registered update. time_up = (current >= limit) && limit != 0, registered every cycle.
- pause=1: prescaler, times and flags hold, sec_tick = 0. A mode change during pause still clears the session.
- clear_total[i]: total[i] goes to 0 on that edge, overriding a same-cycle increment of mode i. Multiple bits may be set at once.
- Latency: every output is registered; there is no combinational path from inputs to outputs.

Decomposition:
- parameters.vh supplies `MODE_WIDTH, `MAX_WIDTH and `COUNTER_1SEC, plus new `NUM_MODES and `TRACK_MASK defaults. Mode code macros stay there.
- Sub-module sec_prescaler (params TICKS_PER_SEC):
  - inputs: clk, rst, clear, enable;
  - output: tick pulse;
  - instantiated once.
- The per-mode total array is a generate loop inside the top module.

Test Plan:
- TICKS_PER_SEC=4, mode 1 held for 12 cycles after reset → sec_tick at cycles 4, 8, 12; current = 3; total[1] = 3; others 0.
- Mode 1 for 10 cycles, then switch to mode 2 → current = 0 on the switch edge; total[1] stays 2; the first mode-2 tick comes 4 cycles after the switch.
- limit = 2 in mode 1 → time_up rises with current = 2 at cycle 8 and stays high at current = 3; a mode change drops it next edge. limit = 0 → time_up never rises.
- TIME_WIDTH=3, run 10 s → current and total saturate at 7; sec_tick keeps pulsing.
- pause high for 5 cycles mid-second → prescaler frozen, next tick delayed by exactly 5 cycles. clear_total[1] on a tick edge → total[1] = 0, not 1.
- rst asserted mid-count in mode 1 → all outputs 0 next edge. current_mode = NUM_MODES (untracked) → no ticks, current = 0.

Source files
------------

// File: rtl/multi_mode_runtime_tracker_pkg.sv
// Shared defaults and session-action encoding for the multi-mode runtime tracker.
package multi_mode_runtime_tracker_pkg;

  localparam int unsigned DEF_NUM_MODES    = 4;
  localparam int unsigned DEF_MODE_WIDTH   = 3;
  localparam int unsigned DEF_MAX_WIDTH    = 16;
  localparam int unsigned DEF_COUNTER_1SEC = 50_000_000;

  typedef enum logic [1:0] {
    SES_IDLE,
    SES_RESTART,
    SES_HOLD,
    SES_RUN
  } session_e;

endpackage

// File: rtl/multi_mode_runtime_tracker_sec_prescaler.sv
// Divides clk down to a one-second tick; tick flags the cycle whose edge wraps the count.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_mode_runtime_tracker.sv
// Per-mode elapsed-seconds tracker: session time, saturating lifetime totals and session limit flag.
module multi_mode_runtime_tracker
  import multi_mode_runtime_tracker_pkg::*;
#(
  parameter int unsigned NUM_MODES     = DEF_NUM_MODES,
  parameter int unsigned MODE_WIDTH    = DEF_MODE_WIDTH,
  parameter int unsigned TIME_WIDTH    = DEF_MAX_WIDTH,
  parameter int unsigned TICKS_PER_SEC = DEF_COUNTER_1SEC,
  parameter logic [NUM_MODES-1:0] TRACK_MASK = {NUM_MODES{1'b1}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MODE_WIDTH-1:0]           current_mode,
  input  logic                            pause,
  input  logic [TIME_WIDTH-1:0]           limit,
  input  logic [NUM_MODES-1:0]            clear_total,
  output logic [TIME_WIDTH-1:0]           current_running_time,
  output logic [NUM_MODES*TIME_WIDTH-1:0] total_running_time,
  output logic                            sec_tick,
  output logic                            time_up,
  output logic [MODE_WIDTH-1:0]           active_idx
);

  logic [MODE_WIDTH-1:0] mode_q;
  logic [TIME_WIDTH-1:0] cur_next;
  logic                  mode_active;
  logic                  time_up_next;
  logic                  presc_clear;
  logic                  presc_en;
  logic                  tick;
  logic                  run_tick;
  session_e              session;

  always_comb begin
    mode_active = 1'b0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (TRACK_MASK[i] && (current_mode == MODE_WIDTH'(i))) mode_active = 1'b1;
    end
  end

  // A mode change restarts the session even while paused, so it is decided first.
  always_comb begin
    if (current_mode != mode_q) session = SES_RESTART;
    else if (!mode_active)      session = SES_IDLE;
    else if (pause)             session = SES_HOLD;
    else                        session = SES_RUN;
  end

  assign presc_clear = (session == SES_RESTART) || (session == SES_IDLE);
  assign presc_en    = (session == SES_RUN);
  assign run_tick    = (session == SES_RUN) && tick;

  always_comb begin
    cur_next     = '0;
    time_up_next = 1'b0;
    case (session)
      SES_HOLD: begin
        cur_next     = current_running_time;
        time_up_next = time_up;
      end
      SES_RUN: begin
        cur_next = current_running_time;
        if (tick && (current_running_time != '1)) cur_next = current_running_time + 1'b1;
        time_up_next = (limit != '0) && (cur_next >= limit);
      end
      default: begin
        cur_next     = '0;
        time_up_next = 1'b0;
      end
    endcase
  end

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .enable(presc_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q               <= current_mode;
      active_idx           <= '0;
      current_running_time <= '0;
      sec_tick             <= 1'b0;
      time_up              <= 1'b0;
    end else begin
      mode_q               <= current_mode;
      active_idx           <= current_mode;
      current_running_time <= cur_next;
      sec_tick             <= run_tick;
      time_up              <= time_up_next;
    end
  end

  for (genvar i = 0; i < NUM_MODES; i++) begin : g_total
    logic [TIME_WIDTH-1:0] total_q;

    always_ff @(posedge clk) begin
      if (rst || clear_total[i]) begin
        total_q <= '0;
      end else if (run_tick && (mode_q == MODE_WIDTH'(i)) && (total_q != '1)) begin
        total_q <= total_q + 1'b1;
      end
    end

    assign total_running_time[i*TIME_WIDTH +: TIME_WIDTH] = total_q;
  end

endmodule

// File: tb/tb_multi_mode_runtime_tracker.sv
// Scoreboard bench for multi_mode_runtime_tracker with a 4-cycle second and a 3-bit saturation copy.
module tb_multi_mode_runtime_tracker;

  localparam int unsigned TW  = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned NM  = 4;
  localparam int unsigned MW  = 3;
  localparam int unsigned TPS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          pause = 1'b0;
  logic [MW-1:0] mode = '0;
  logic [TW-1:0] limit = '0;
  logic [SW-1:0] limit_s = '0;
  logic [NM-1:0] clr = '0;

  logic [TW-1:0]    cur;
  logic [NM*TW-1:0] tot;
  logic             tick, tu;
  logic [MW-1:0]    aidx;
  logic [SW-1:0]    s_cur;
  logic [NM*SW-1:0] s_tot;
  logic             s_tick, s_tu;
  logic [MW-1:0]    s_aidx;

  multi_mode_runtime_tracker #(
    .NUM_MODES(NM), .MODE_WIDTH(MW), .TIME_WIDTH(TW), .TICKS_PER_SEC(TPS), .TRACK_MASK(4'b1111)
  ) dut (
    .clk(clk), .rst(rst), .current_mode(mode), .pause(pause), .limit(limit),
    .clear_total(clr), .current_running_time(cur), .total_running_time(tot),
    .sec_tick(tick), .time_up(tu), .active_idx(aidx)
  );

  multi_mode_runtime_tracker #(
    .NUM_MODES(NM), .MODE_WIDTH(MW), .TIME_WIDTH(SW), .TICKS_PER_SEC(TPS), .TRACK_MASK(4'b1111)
  ) dut_s (
    .clk(clk), .rst(rst), .current_mode(mode), .pause(pause), .limit(limit_s),
    .clear_total(clr), .current_running_time(s_cur), .total_running_time(s_tot),
    .sec_tick(s_tick), .time_up(s_tu), .active_idx(s_aidx)
  );

  typedef struct {
    logic [TW-1:0] cur;
    logic          tick;
    logic          tu;
    logic [TW-1:0] tot;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [TW-1:0] tot_of(input int i);
    return tot[i*TW +: TW];
  endfunction

  task automatic apply_reset(input logic [MW-1:0] m);
    rst = 1'b1; mode = m; pause = 1'b0; clr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 3'd1;
    @(posedge clk); #1;
    checks++;
    if ({cur, tick, tu, aidx} !== {TW'(0), 1'b0, 1'b0, MW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs cur=%0d tick=%b tu=%b aidx=%0d want 0", cur, tick, tu, aidx);
    end
    checks++;
    if (tot !== '0 || s_tot !== '0) begin
      errors++;
      $display("FAIL reset_totals got %h/%h want 0", tot, s_tot);
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    exp_t e;
    limit = '0;
    apply_reset(3'd1);
    for (int n = 1; n <= 12; n++) begin
      e.cur = TW'(n / 4); e.tick = (n % 4 == 0); e.tu = 1'b0; e.tot = TW'(n / 4);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tick, tu, tot_of(1)} !== {e.cur, e.tick, e.tu, e.tot}) begin
        errors++;
        $display("FAIL count n=%0d cur/tick/tu/tot1 got %0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 n, cur, tick, tu, tot_of(1), e.cur, e.tick, e.tu, e.tot);
      end
    end
    checks++;
    if ({tot_of(0), tot_of(2), tot_of(3)} !== '0 || aidx !== 3'd1) begin
      errors++;
      $display("FAIL count_others tot0/2/3=%0d/%0d/%0d aidx=%0d want 0/0/0 aidx 1",
               tot_of(0), tot_of(2), tot_of(3), aidx);
    end
  endtask

  task automatic test_mode_switch();
    exp_t e;
    apply_reset(3'd1);
    for (int n = 1; n <= 10; n++) begin
      e.cur = TW'(n / 4); e.tick = (n % 4 == 0); e.tu = 1'b0; e.tot = TW'(n / 4);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tick, tot_of(1)} !== {e.cur, e.tick, e.tot}) begin
        errors++;
        $display("FAIL switch_pre n=%0d got %0d/%b/%0d want %0d/%b/%0d",
                 n, cur, tick, tot_of(1), e.cur, e.tick, e.tot);
      end
    end
    mode = 3'd2;
    e.cur = '0; e.tick = 1'b0; e.tu = 1'b0; e.tot = TW'(2);
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if ({cur, tick, tot_of(1), aidx} !== {e.cur, e.tick, e.tot, MW'(2)}) begin
      errors++;
      $display("FAIL switch_edge cur=%0d tick=%b tot1=%0d aidx=%0d want 0/0/2/2", cur, tick, tot_of(1), aidx);
    end
    for (int n = 1; n <= 4; n++) begin
      e.cur = TW'(n / 4); e.tick = (n == 4); e.tu = 1'b0; e.tot = TW'(n / 4);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tick, tot_of(2), tot_of(1)} !== {e.cur, e.tick, e.tot, TW'(2)}) begin
        errors++;
        $display("FAIL switch_post n=%0d cur/tick/tot2/tot1 got %0d/%b/%0d/%0d want %0d/%b/%0d/2",
                 n, cur, tick, tot_of(2), tot_of(1), e.cur, e.tick, e.tot);
      end
    end
  endtask

  task automatic test_limit();
    exp_t e;
    limit = TW'(2);
    apply_reset(3'd1);
    for (int n = 1; n <= 12; n++) begin
      e.cur = TW'(n / 4); e.tick = (n % 4 == 0); e.tu = (n >= 8); e.tot = '0;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tick, tu} !== {e.cur, e.tick, e.tu}) begin
        errors++;
        $display("FAIL limit n=%0d cur/tick/tu got %0d/%b/%b want %0d/%b/%b", n, cur, tick, tu, e.cur, e.tick, e.tu);
      end
    end
    mode = 3'd2;
    @(posedge clk); #1;
    checks++;
    if ({cur, tu} !== {TW'(0), 1'b0}) begin
      errors++;
      $display("FAIL limit_drop cur=%0d tu=%b want 0/0", cur, tu);
    end
    limit = '0;
    apply_reset(3'd1);
    for (int n = 1; n <= 12; n++) begin
      e.cur = TW'(n / 4); e.tick = (n % 4 == 0); e.tu = 1'b0; e.tot = '0;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tu} !== {e.cur, e.tu}) begin
        errors++;
        $display("FAIL limit_zero n=%0d cur/tu got %0d/%b want %0d/%b", n, cur, tu, e.cur, e.tu);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    limit_s = '0;
    apply_reset(3'd1);
    for (int n = 1; n <= 40; n++) begin
      e.cur = TW'((n / 4 > 7) ? 7 : n / 4); e.tick = (n % 4 == 0); e.tu = 1'b0; e.tot = e.cur;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({s_cur, s_tick, s_tot[SW +: SW]} !== {e.cur[SW-1:0], e.tick, e.tot[SW-1:0]}) begin
        errors++;
        $display("FAIL saturate n=%0d cur/tick/tot1 got %0d/%b/%0d want %0d/%b/%0d",
                 n, s_cur, s_tick, s_tot[SW +: SW], e.cur, e.tick, e.tot);
      end
    end
  endtask

  task automatic test_pause_and_clear();
    exp_t e;
    limit = '0;
    apply_reset(3'd1);
    for (int n = 1; n <= 20; n++) begin
      // 6 counted cycles, 5 paused, 2 to the delayed tick, 3 quiet, then the clear on the tick edge
      pause = (n >= 7 && n <= 11);
      clr   = (n == 17) ? 4'b0010 : 4'b0000;
      case (n)
        1, 2, 3:    begin e.cur = 0; e.tick = 0; e.tot = 0; end
        4:          begin e.cur = 1; e.tick = 1; e.tot = 1; end
        13:         begin e.cur = 2; e.tick = 1; e.tot = 2; end
        14, 15, 16: begin e.cur = 2; e.tick = 0; e.tot = 2; end
        17:         begin e.cur = 3; e.tick = 1; e.tot = 0; end
        18, 19, 20: begin e.cur = 3; e.tick = 0; e.tot = 0; end
        default:    begin e.cur = 1; e.tick = 0; e.tot = 1; end
      endcase
      e.tu = 1'b0;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({cur, tick, tot_of(1)} !== {e.cur, e.tick, e.tot}) begin
        errors++;
        $display("FAIL pause_clear n=%0d cur/tick/tot1 got %0d/%b/%0d want %0d/%b/%0d",
                 n, cur, tick, tot_of(1), e.cur, e.tick, e.tot);
      end
    end
    clr = '0;
    @(posedge clk); #1;
    checks++;
    if ({cur, tick, tot_of(1)} !== {TW'(4), 1'b1, TW'(1)}) begin
      errors++;
      $display("FAIL clear_recount cur/tick/tot1 got %0d/%b/%0d want 4/1/1", cur, tick, tot_of(1));
    end
    pause = 1'b1; mode = 3'd2;
    @(posedge clk); #1;
    checks++;
    if ({cur, tick, aidx, tot_of(1)} !== {TW'(0), 1'b0, MW'(2), TW'(1)}) begin
      errors++;
      $display("FAIL pause_switch cur/tick/aidx/tot1 got %0d/%b/%0d/%0d want 0/0/2/1", cur, tick, aidx, tot_of(1));
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_mid();
    limit = TW'(1);
    apply_reset(3'd1);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if ({cur, tu} !== {TW'(1), 1'b1}) begin
      errors++;
      $display("FAIL premid cur/tu got %0d/%b want 1/1", cur, tu);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cur, tick, tu, aidx} !== {TW'(0), 1'b0, 1'b0, MW'(0)} || tot !== '0) begin
      errors++;
      $display("FAIL reset_mid cur/tick/tu/aidx got %0d/%b/%b/%0d tot=%h want all 0", cur, tick, tu, aidx, tot);
    end
    rst = 1'b0;
    limit = '0;
  endtask

  task automatic test_untracked();
    limit = TW'(1);
    apply_reset(3'(NM));
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      checks++;
      if ({cur, tick, tu} !== {TW'(0), 1'b0, 1'b0} || tot !== '0) begin
        errors++;
        $display("FAIL untracked n=%0d cur/tick/tu got %0d/%b/%b tot=%h want 0", n, cur, tick, tu, tot);
      end
    end
    limit = '0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_mode_switch();
    test_limit();
    test_saturation();
    test_pause_and_clear();
    test_reset_mid();
    test_untracked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
